mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Owns the single memory port shared by CPU and IOP; replaces the ad-hoc cpu_active toggle.
//  Muxes address/write data/byte enables from the current owner to Memory; broadcasts read data.
//  Ownership passes via doorbell writes: CPU->IOP on write to CPU_DOORBELL, IOP->CPU on IOP_DOORBELL.
//  A drain gap between owners lets the 1-cycle synchronous read finish before the bus changes hands.
// PARAMETERS
//  CPU_DOORBELL    17'h20  word address; CPU byte-0 write here hands the bus to the IOP
//  IOP_DOORBELL    17'h21  word address; IOP byte-0 write here hands the bus to the CPU
//  GAP_CYCLES      1       idle drain cycles per handoff, >=1
//  WATCHDOG_LIMIT  256     max IOP ownership cycles (ARB_WATCHDOG_EN only)
// PORTS
//  clock           in   1      system clock, all state on posedge
//  reset           in   1      synchronous, active-high
//  cpu_address     in   17     [15:31] CPU word address
//  cpu_data_out    in   32     [0:31] CPU write data
//  cpu_write_en    in   4      [0:3] CPU byte enables
//  iop_address     in   17     [15:31] IOP word address
//  iop_data_out    in   32     [0:31] IOP write data
//  iop_write_en    in   4      [0:3] IOP byte enables
//  mem_data_out    in   32     read data from Memory
//  mem_address     out  17     to Memory
//  mem_data_in     out  32     to Memory
//  mem_write_en    out  4      to Memory
//  rd_data         out  32     mem_data_out, unregistered, to both masters
//  cpu_active      out  1      CPU owns bus (drives CPU enable)
//  iop_active      out  1      IOP owns bus
//  bus_error       out  1      sticky: non-owner asserted any write_en bit
//  watchdog_fired  out  1      sticky: watchdog reclaimed bus (0 if macro off)
// BEHAVIOUR
//  States: CPU_OWN, GAP_TO_IOP, IOP_OWN, GAP_TO_CPU; encoding registered, outputs decoded from it.
//  Reset (sync): CPU_OWN; cpu_active=1, iop_active=0, bus_error=0, watchdog_fired=0, counters 0.
//  CPU_OWN: mem_* = cpu_*; cpu_write_en[0] & cpu_address==CPU_DOORBELL -> GAP_TO_IOP next cycle.
//   The doorbell write itself reaches Memory in that cycle.
//  GAP_*: mem_write_en=0, mem_address=0, mem_data_in=0; cpu_active=iop_active=0;
//   stays GAP_CYCLES cycles (down-counter), then enters the target OWN state.
//  IOP_OWN: mem_* = iop_*; iop_write_en[0] & iop_address==IOP_DOORBELL -> GAP_TO_CPU.
//  Doorbell requires byte 0 enabled; a write to the doorbell address with only bytes 1-3 enabled
//   is an ordinary write.
//  Non-owner write_en!=0 in any state: write dropped, bus_error set (held until reset).
//  Doorbells presented during GAP states are ignored; they are not queued.
//  Simultaneous doorbells from both masters: only the owner's counts; the other sets bus_error.
//  Reset asserted mid-handoff: returns to CPU_OWN next edge, no write issued that cycle.
//  Latency: mux is combinational from state; rd_data valid one cycle after the address, unchanged.
//  The owner-to-owner handoff is exactly 1 + GAP_CYCLES cycles after the doorbell edge.
// CONFIGURATION
//  ARB_WATCHDOG_EN defined: counter clears on IOP_OWN entry and increments each IOP_OWN cycle.
//   At WATCHDOG_LIMIT with no doorbell: -> GAP_TO_CPU, watchdog_fired set (sticky).
//   Doorbell and limit reached in the same cycle: doorbell path taken, watchdog_fired stays 0.
//  Macro undefined: no counter; IOP may hold the bus indefinitely; watchdog_fired tied 0.
// STRUCTURE
//  Shared package bus_defs.vh: ADDR_W=17, DATA_W=32, BE_W=4, state encodings,
//   default doorbell addresses.
//  One sub-module arb_timer: loadable down-counter shared by gap and watchdog timing.
// TESTING
//  Reset, idle: cpu_active=1, iop_active=0, mem_address==cpu_address.
//  CPU writes be=4'b1000 to 17'h20 at T: write seen by Memory at T; cpu_active=0 at T+1;
//   iop_active=1 at T+2 (GAP_CYCLES=1).
//  IOP writes 17'h21 be=4'b1000: reverse handoff with identical timing;
//   CPU reads word 5 afterwards returns the IOP-written value.
//  CPU writes 17'h20 with be=4'b0001: normal write, no handoff.
//  IOP asserts write_en during CPU_OWN: mem_write_en stays 0, bus_error=1 until reset.
//  ARB_WATCHDOG_EN, WATCHDOG_LIMIT=8, IOP silent: cpu_active=1 after 8+1+GAP cycles,
//   watchdog_fired=1.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared widths, ownership state encoding and default doorbell addresses for the
// CPU/IOP memory-port arbiter.
package mem_bus_arbiter_pkg;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    // Byte lane 0 is the most significant lane, so it lives in the top enable bit.
    localparam int BYTE0 = BE_W - 1;

    localparam logic [ADDR_W-1:0] DEF_CPU_DOORBELL = 17'h20;
    localparam logic [ADDR_W-1:0] DEF_IOP_DOORBELL = 17'h21;

    typedef enum logic [1:0] {
        CPU_OWN    = 2'd0,
        GAP_TO_IOP = 2'd1,
        IOP_OWN    = 2'd2,
        GAP_TO_CPU = 2'd3
    } arb_state_t;

    function automatic logic is_doorbell(input logic [ADDR_W-1:0] addr,
                                         input logic [BE_W-1:0]   be,
                                         input logic [ADDR_W-1:0] bell);
        return be[BYTE0] && (addr == bell);
    endfunction

    // Down-counter width large enough for both the gap and the watchdog reload values.
    function automatic int timer_width(input int gap, input int limit);
        int m;
        m = (gap > limit) ? gap : limit;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and Memory.
// master = the environment side (CPU, IOP, Memory); slave = the arbiter.
interface mem_bus_arbiter_if;
    import mem_bus_arbiter_pkg::*;

    logic [ADDR_W-1:0] cpu_address;
    logic [DATA_W-1:0] cpu_data_out;
    logic [BE_W-1:0]   cpu_write_en;
    logic [ADDR_W-1:0] iop_address;
    logic [DATA_W-1:0] iop_data_out;
    logic [BE_W-1:0]   iop_write_en;
    logic [DATA_W-1:0] mem_data_out;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic [BE_W-1:0]   mem_write_en;
    logic [DATA_W-1:0] rd_data;
    logic              cpu_active;
    logic              iop_active;
    logic              bus_error;
    logic              watchdog_fired;

    modport master (
        output cpu_address, cpu_data_out, cpu_write_en,
        output iop_address, iop_data_out, iop_write_en,
        output mem_data_out,
        input  mem_address, mem_data_in, mem_write_en, rd_data,
        input  cpu_active, iop_active, bus_error, watchdog_fired
    );

    modport slave (
        input  cpu_address, cpu_data_out, cpu_write_en,
        input  iop_address, iop_data_out, iop_write_en,
        input  mem_data_out,
        output mem_address, mem_data_in, mem_write_en, rd_data,
        output cpu_active, iop_active, bus_error, watchdog_fired
    );

endinterface

// File: rtl/mem_bus_arbiter_timer.sv
// Loadable down-counter shared by the handoff drain gap and the IOP watchdog.
// Load wins over decrement; the count saturates at zero.
module mem_bus_arbiter_timer #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Owner of the single memory port shared by CPU and IOP; ownership moves on doorbell
// writes with a drain gap between owners. Optional IOP watchdog: define ARB_WATCHDOG_EN.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter logic [ADDR_W-1:0] CPU_DOORBELL   = DEF_CPU_DOORBELL,
    parameter logic [ADDR_W-1:0] IOP_DOORBELL   = DEF_IOP_DOORBELL,
    parameter int                GAP_CYCLES     = 1,
    parameter int                WATCHDOG_LIMIT = 256
) (
    input  logic               clock,
    input  logic               reset,
    mem_bus_arbiter_if.slave   bus,
    output arb_state_t         o_state
);

    localparam int              TMR_W    = timer_width(GAP_CYCLES, WATCHDOG_LIMIT);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYCLES - 1);

    arb_state_t       r_state;
    logic             r_cpu_active;
    logic             r_iop_active;
    logic             r_bus_error;

    logic             w_cpu_bell;
    logic             w_iop_bell;
    logic             w_violation;
    logic             w_tmr_zero;
    logic             w_tmr_load;
    logic             w_tmr_dec;
    logic [TMR_W-1:0] w_tmr_val;

`ifdef ARB_WATCHDOG_EN
    localparam logic [TMR_W-1:0] WD_LOAD = TMR_W'(WATCHDOG_LIMIT - 1);
    logic             r_wd_fired;
`endif

    assign w_cpu_bell = is_doorbell(bus.cpu_address, bus.cpu_write_en, CPU_DOORBELL);
    assign w_iop_bell = is_doorbell(bus.iop_address, bus.iop_write_en, IOP_DOORBELL);

    // Whoever is not the owner must keep its enables low; during a gap nobody owns the bus.
    assign w_violation = ((r_state != CPU_OWN) && (bus.cpu_write_en != '0)) ||
                         ((r_state != IOP_OWN) && (bus.iop_write_en != '0));

    // A load of N-1 on entry gives N cycles in the state before the timer reads zero.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_dec  = 1'b0;
        w_tmr_val  = GAP_LOAD;
        case (r_state)
            CPU_OWN: begin
                w_tmr_load = w_cpu_bell;
            end
            GAP_TO_IOP: begin
                w_tmr_dec = !w_tmr_zero;
`ifdef ARB_WATCHDOG_EN
                if (w_tmr_zero) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = WD_LOAD;
                end
`endif
            end
            IOP_OWN: begin
`ifdef ARB_WATCHDOG_EN
                w_tmr_load = w_iop_bell || w_tmr_zero;
                w_tmr_dec  = !w_iop_bell && !w_tmr_zero;
`else
                w_tmr_load = w_iop_bell;
`endif
            end
            GAP_TO_CPU: begin
                w_tmr_dec = !w_tmr_zero;
            end
            default: begin
                w_tmr_load = 1'b0;
            end
        endcase
    end

    mem_bus_arbiter_timer #(
        .W (TMR_W)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= CPU_OWN;
            r_cpu_active <= 1'b1;
            r_iop_active <= 1'b0;
            r_bus_error  <= 1'b0;
`ifdef ARB_WATCHDOG_EN
            r_wd_fired   <= 1'b0;
`endif
        end else begin
            if (w_violation) begin
                r_bus_error <= 1'b1;
            end
            case (r_state)
                CPU_OWN: begin
                    if (w_cpu_bell) begin
                        r_state      <= GAP_TO_IOP;
                        r_cpu_active <= 1'b0;
                    end
                end
                GAP_TO_IOP: begin
                    if (w_tmr_zero) begin
                        r_state      <= IOP_OWN;
                        r_iop_active <= 1'b1;
                    end
                end
                IOP_OWN: begin
                    // A doorbell in the limit cycle is a normal handoff, not a watchdog event.
                    if (w_iop_bell) begin
                        r_state      <= GAP_TO_CPU;
                        r_iop_active <= 1'b0;
                    end
`ifdef ARB_WATCHDOG_EN
                    else if (w_tmr_zero) begin
                        r_state      <= GAP_TO_CPU;
                        r_iop_active <= 1'b0;
                        r_wd_fired   <= 1'b1;
                    end
`endif
                end
                GAP_TO_CPU: begin
                    if (w_tmr_zero) begin
                        r_state      <= CPU_OWN;
                        r_cpu_active <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= CPU_OWN;
                    r_cpu_active <= 1'b1;
                    r_iop_active <= 1'b0;
                end
            endcase
        end
    end

    // Memory port mux is purely a function of the registered owner; gaps drive zeros.
    always_comb begin
        bus.mem_address  = '0;
        bus.mem_data_in  = '0;
        bus.mem_write_en = '0;
        case (r_state)
            CPU_OWN: begin
                bus.mem_address  = bus.cpu_address;
                bus.mem_data_in  = bus.cpu_data_out;
                bus.mem_write_en = bus.cpu_write_en;
            end
            IOP_OWN: begin
                bus.mem_address  = bus.iop_address;
                bus.mem_data_in  = bus.iop_data_out;
                bus.mem_write_en = bus.iop_write_en;
            end
            default: begin
                bus.mem_address = '0;
            end
        endcase
        if (reset) begin
            bus.mem_write_en = '0;
        end
    end

    assign bus.rd_data    = bus.mem_data_out;
    assign bus.cpu_active = r_cpu_active;
    assign bus.iop_active = r_iop_active;
    assign bus.bus_error  = r_bus_error;
`ifdef ARB_WATCHDOG_EN
    assign bus.watchdog_fired = r_wd_fired;
`else
    assign bus.watchdog_fired = 1'b0;
`endif
    assign o_state = r_state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed handoff scenarios then random traffic, all checked
// against a timestamp-based ownership model and a reference memory.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int TB_GAP = 1;
`ifdef ARB_WATCHDOG_EN
    localparam int TB_WD_LIMIT = 8;
`else
    localparam int TB_WD_LIMIT = 256;
`endif
    localparam logic [16:0] CPU_BELL = 17'h20;
    localparam logic [16:0] IOP_BELL = 17'h21;
    localparam int OWN_CPU  = 0;
    localparam int OWN_IOP  = 1;
    localparam int OWN_NONE = 2;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mem_bus_arbiter_if bus();
    arb_state_t dbg_state;

    mem_bus_arbiter #(
        .CPU_DOORBELL   (CPU_BELL),
        .IOP_DOORBELL   (IOP_BELL),
        .GAP_CYCLES     (TB_GAP),
        .WATCHDOG_LIMIT (TB_WD_LIMIT)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .o_state (dbg_state)
    );

    // Memory: 1-cycle synchronous read (old data), byte-lane writes.
    logic [31:0] mem [64] = '{default: '0};
    always @(posedge clock) begin
        bus.mem_data_out <= mem[bus.mem_address[5:0]];
        for (int b = 0; b < 4; b++) begin
            if (bus.mem_write_en[b]) mem[bus.mem_address[5:0]][8*b +: 8] <= bus.mem_data_in[8*b +: 8];
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int cyc = 0;
    int m_owner = OWN_CPU;
    int m_next = OWN_CPU;
    int m_switch = 0;
    int m_iop_entry = 0;
    bit m_berr = 1'b0;
    bit m_wd = 1'b0;
    logic [31:0] ref_mem [64] = '{default: '0};

    // ---------------- driver ----------------
    // Entered between negedge and posedge; returns shortly after the next negedge.
    task automatic do_cycle(input logic [16:0] ca, input logic [31:0] cd, input logic [3:0] cw,
                            input logic [16:0] ia, input logic [31:0] id, input logic [3:0] iw,
                            input bit rst);
        logic [16:0] ea;
        logic [31:0] ed;
        logic [3:0]  ew;
        logic [31:0] er;
        bus.cpu_address  = ca;
        bus.cpu_data_out = cd;
        bus.cpu_write_en = cw;
        bus.iop_address  = ia;
        bus.iop_data_out = id;
        bus.iop_write_en = iw;
        reset            = rst;
        ea = '0; ed = '0; ew = '0;
        if (m_owner == OWN_CPU) begin
            ea = ca; ed = cd; ew = cw;
        end else if (m_owner == OWN_IOP) begin
            ea = ia; ed = id; ew = iw;
        end
        if (rst) ew = '0;
        #1;
        er = 32'hxxxx_xxxx;
        if (exp_q.size() != 0) er = exp_q.pop_front();
        check("mem_address", 32'(bus.mem_address), 32'(ea));
        check("mem_data_in", bus.mem_data_in, ed);
        check("mem_write_en", 32'(bus.mem_write_en), 32'(ew));
        check("rd_data", bus.rd_data, er);
        check("cpu_active", 32'(bus.cpu_active), 32'(m_owner == OWN_CPU));
        check("iop_active", 32'(bus.iop_active), 32'(m_owner == OWN_IOP));
        check("bus_error", 32'(bus.bus_error), 32'(m_berr));
        check("watchdog_fired", 32'(bus.watchdog_fired), 32'(m_wd));
        @(posedge clock);
        exp_q.push_back(ref_mem[ea[5:0]]);
        if (rst) begin
            m_owner = OWN_CPU;
            m_berr  = 1'b0;
            m_wd    = 1'b0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (ew[b]) ref_mem[ea[5:0]][8*b +: 8] = ed[8*b +: 8];
            end
            if ((m_owner != OWN_CPU && cw != 0) || (m_owner != OWN_IOP && iw != 0)) m_berr = 1'b1;
            if (m_owner == OWN_CPU && cw[3] && ca == CPU_BELL) begin
                m_owner = OWN_NONE; m_next = OWN_IOP; m_switch = cyc + 1 + TB_GAP;
            end else if (m_owner == OWN_IOP && iw[3] && ia == IOP_BELL) begin
                m_owner = OWN_NONE; m_next = OWN_CPU; m_switch = cyc + 1 + TB_GAP;
            end
`ifdef ARB_WATCHDOG_EN
            else if (m_owner == OWN_IOP && (cyc - m_iop_entry) == TB_WD_LIMIT - 1) begin
                m_owner = OWN_NONE; m_next = OWN_CPU; m_switch = cyc + 1 + TB_GAP; m_wd = 1'b1;
            end
`endif
            else if (m_owner == OWN_NONE && cyc + 1 == m_switch) begin
                m_owner = m_next;
                if (m_next == OWN_IOP) m_iop_entry = cyc + 1;
            end
        end
        cyc++;
        @(negedge clock);
        #2;
    endtask

    task automatic idle();
        do_cycle(17'd0, 32'd0, 4'd0, 17'd0, 32'd0, 4'd0, 1'b0);
    endtask

    function automatic logic [16:0] pick_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 2) return CPU_BELL;
        if (r < 4) return IOP_BELL;
        return 17'($urandom_range(0, 15));
    endfunction

    task automatic rand_cycle(input bit allow_viol);
        logic [3:0] cw;
        logic [3:0] iw;
        cw = '0;
        iw = '0;
        if (m_owner == OWN_CPU && $urandom_range(0, 1) == 1) cw = 4'($urandom_range(1, 15));
        if (m_owner == OWN_IOP && $urandom_range(0, 1) == 1) iw = 4'($urandom_range(1, 15));
        if (allow_viol && m_owner != OWN_CPU && $urandom_range(0, 39) == 0) cw = 4'($urandom_range(1, 15));
        if (allow_viol && m_owner != OWN_IOP && $urandom_range(0, 39) == 0) iw = 4'($urandom_range(1, 15));
        do_cycle(pick_addr(), $urandom, cw, pick_addr(), $urandom, iw, ($urandom_range(0, 149) == 0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        bus.cpu_address = '0; bus.cpu_data_out = '0; bus.cpu_write_en = '0;
        bus.iop_address = '0; bus.iop_data_out = '0; bus.iop_write_en = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        #2;
        exp_q.push_back(32'd0);

        check("rst_cpu_active", 32'(bus.cpu_active), 32'd1);
        check("rst_iop_active", 32'(bus.iop_active), 32'd0);
        check("rst_bus_error", 32'(bus.bus_error), 32'd0);
        check("rst_watchdog", 32'(bus.watchdog_fired), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(CPU_OWN));

        do_cycle(17'd7, 32'h0, 4'd0, 17'd3, 32'h0, 4'd0, 1'b0);
        check("idle_mux_addr", 32'(bus.mem_address), 32'd7);

        // CPU doorbell: write lands at T, CPU off at T+1, IOP on at T+2
        do_cycle(CPU_BELL, 32'h1122_3344, 4'b1000, 17'd0, 32'h0, 4'd0, 1'b0);
        check("hand_t1_cpu", 32'(bus.cpu_active), 32'd0);
        check("hand_t1_iop", 32'(bus.iop_active), 32'd0);
        idle();
        check("hand_t2_iop", 32'(bus.iop_active), 32'd1);

        // IOP writes word 5, rings back, CPU reads it
        do_cycle(17'd0, 32'h0, 4'd0, 17'd5, 32'hCAFE_F00D, 4'hF, 1'b0);
        do_cycle(17'd0, 32'h0, 4'd0, IOP_BELL, 32'h0, 4'b1000, 1'b0);
        check("back_t1_iop", 32'(bus.iop_active), 32'd0);
        check("back_t1_cpu", 32'(bus.cpu_active), 32'd0);
        idle();
        check("back_t2_cpu", 32'(bus.cpu_active), 32'd1);
        do_cycle(17'd5, 32'h0, 4'd0, 17'd0, 32'h0, 4'd0, 1'b0);
        check("rd_word5", bus.rd_data, 32'hCAFE_F00D);

        // Doorbell address with only lane 3 enabled is an ordinary write
        do_cycle(CPU_BELL, 32'hA5A5_A5A5, 4'b0001, 17'd0, 32'h0, 4'd0, 1'b0);
        check("lane3_no_hand", 32'(bus.cpu_active), 32'd1);

        // Non-owner write is dropped and latches bus_error
        do_cycle(17'd9, 32'h0, 4'd0, 17'd9, 32'hDEAD_BEEF, 4'hF, 1'b0);
        check("viol_berr", 32'(bus.bus_error), 32'd1);
        repeat (3) idle();
        check("viol_sticky", 32'(bus.bus_error), 32'd1);

        // Reset in the middle of a handoff
        do_cycle(CPU_BELL, 32'h0, 4'b1000, 17'd0, 32'h0, 4'd0, 1'b0);
        do_cycle(17'd2, 32'h1234_5678, 4'hF, 17'd0, 32'h0, 4'd0, 1'b1);
        check("rst_mid_cpu", 32'(bus.cpu_active), 32'd1);
        check("rst_mid_berr", 32'(bus.bus_error), 32'd0);
        // Reset while the CPU is writing: the write must not reach Memory
        do_cycle(17'd3, 32'hFFFF_FFFF, 4'hF, 17'd0, 32'h0, 4'd0, 1'b1);
        do_cycle(17'd3, 32'h0, 4'd0, 17'd0, 32'h0, 4'd0, 1'b0);
        check("rst_no_write", bus.rd_data, 32'd0);

`ifdef ARB_WATCHDOG_EN
        do_cycle(CPU_BELL, 32'h0, 4'b1000, 17'd0, 32'h0, 4'd0, 1'b0);
        idle();
        check("wd_iop_on", 32'(bus.iop_active), 32'd1);
        repeat (TB_WD_LIMIT) idle();
        check("wd_gap", 32'(bus.iop_active), 32'd0);
        check("wd_fired", 32'(bus.watchdog_fired), 32'd1);
        repeat (TB_GAP) idle();
        check("wd_cpu_back", 32'(bus.cpu_active), 32'd1);
`endif

        repeat (300) rand_cycle(1'b0);
        repeat (300) rand_cycle(1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
